// File: rtl/serial_key_matrix.sv
// serial_key_matrix
//   Turns UART bytes into Galaksija keyboard-matrix state for the CPU key window.
//   Received bytes are queued in a FIFO. Each byte is replayed as a timed press
//   (HOLD_CYCLES) followed by an all-released gap (GAP_CYCLES). This lets keys
//   survive ROM scan latency, and a burst of typing loses no key state.
//
// Build option:
//   SERKBD_ANSI_EN  When defined, ESC '[' A/B/C/D is decoded to the cursor keys.
//                   When undefined, ESC is a plain BREAK key.
//
// Ports:
//   clk       in   system clock
//   reset_n   in   synchronous, active-low reset
//   rx_data   in   [7:0] byte from uart_rx
//   rx_valid  in   one-cycle strobe qualifying rx_data
//   rd_key    in   CPU key-window read strobe
//   key_addr  in   [5:0] matrix index (CPU addr[5:0])
//   key_out   out  [7:0] FE = key pressed, FF = released (1-cycle read latency)
//   busy      out  FSM active or FIFO holding bytes
//   overflow  out  sticky: a byte was dropped on a full FIFO
module serial_key_matrix #(
    parameter int unsigned F_CLK       = 25000000,
    parameter int unsigned HOLD_CYCLES = F_CLK / 50,   // 20 ms
    parameter int unsigned GAP_CYCLES  = F_CLK / 100,  // 10 ms
    parameter int unsigned FIFO_AW     = 4,
    parameter int unsigned ESC_TIMEOUT = F_CLK / 100
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    input  logic       rd_key,
    input  logic [5:0] key_addr,
    output logic [7:0] key_out,
    output logic       busy,
    output logic       overflow
);

    localparam int unsigned DEPTH   = 2 ** FIFO_AW;
    localparam int unsigned MAX_HG  = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int unsigned MAX_CNT = (MAX_HG > ESC_TIMEOUT) ? MAX_HG : ESC_TIMEOUT;
    localparam int unsigned CNT_W   = $clog2(MAX_CNT + 1);

    localparam logic [5:0] KEY_BREAK = 6'd49;
    localparam int unsigned KEY_SHIFT = 53;

    // ---------------------------------------------------------------- FIFO
    logic [7:0]         fifo_mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [FIFO_AW:0]   count_q;
    logic               overflow_q;
    logic               fifo_empty, fifo_full, push, pop;
    logic [7:0]         fifo_rdata;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == (FIFO_AW + 1)'(DEPTH));
    // A full FIFO still accepts a byte when a pop frees a slot in the same cycle.
    assign push       = rx_valid && (!fifo_full || pop);
    assign fifo_rdata = fifo_mem[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (push && !pop)      count_q <= count_q + 1'b1;
            else if (pop && !push) count_q <= count_q - 1'b1;
            if (rx_valid && !push) overflow_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr_q] <= rx_data;
    end

    // ------------------------------------------------------------ key map
    // Returns {hit, shift, index[5:0]}.
    function automatic logic [7:0] map_byte(input logic [7:0] b);
        logic [7:0] r;
        r = 8'h00;
        if (b >= 8'h41 && b <= 8'h5A)      r = {2'b10, 6'(b - 8'h40)};
        else if (b >= 8'h61 && b <= 8'h7A) r = {2'b10, 6'(b - 8'h60)};
        else if (b >= 8'h30 && b <= 8'h39) r = {2'b10, 6'(b - 8'h10)};
        else begin
            case (b)
                8'h0A, 8'h0D: r = {2'b10, 6'd48};
                8'h08, 8'h7F: r = {2'b10, 6'd29};
                8'h1B:        r = {2'b10, KEY_BREAK};
                8'h20:        r = {2'b10, 6'd31};
                8'h5F:        r = {2'b11, 6'd32};  // _
                8'h21:        r = {2'b11, 6'd33};  // !
                8'h22:        r = {2'b11, 6'd34};  // "
                8'h23:        r = {2'b11, 6'd35};  // #
                8'h24:        r = {2'b11, 6'd36};  // $
                8'h25:        r = {2'b11, 6'd37};  // %
                8'h26:        r = {2'b11, 6'd38};  // &
                8'h5C:        r = {2'b11, 6'd39};  // backslash
                8'h28:        r = {2'b11, 6'd40};  // (
                8'h29:        r = {2'b11, 6'd41};  // )
                8'h2B:        r = {2'b11, 6'd42};  // +
                8'h2A:        r = {2'b11, 6'd43};  // *
                8'h3C:        r = {2'b11, 6'd44};  // <
                8'h2D:        r = {2'b11, 6'd45};  // -
                8'h3E:        r = {2'b11, 6'd46};  // >
                8'h3F:        r = {2'b11, 6'd47};  // ?
                8'h3B:        r = {2'b10, 6'd42};  // ;
                8'h3A:        r = {2'b10, 6'd43};  // :
                8'h2C:        r = {2'b10, 6'd44};  // ,
                8'h3D:        r = {2'b10, 6'd45};  // =
                8'h2E:        r = {2'b10, 6'd46};  // .
                8'h2F:        r = {2'b10, 6'd47};  // /
                default:      r = 8'h00;
            endcase
        end
        return r;
    endfunction

    // ----------------------------------------------------------------- FSM
`ifdef SERKBD_ANSI_EN
    typedef enum logic [3:0] {
        StIdle, StPop, StMap, StPress, StHold, StRelease, StGap, StEsc1, StEsc2
    } state_e;
`else
    typedef enum logic [3:0] {
        StIdle, StPop, StMap, StPress, StHold, StRelease, StGap
    } state_e;
`endif

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       cur_q, cur_d;
    logic [5:0]       k_q, k_d;
    logic             s_q, s_d;
    logic [63:0]      keys_q, keys_d;
    logic [7:0]       map_r;
`ifdef SERKBD_ANSI_EN
    // Set when ESC was followed by a non-'[' byte: after BREAK, that byte is mapped.
    logic             pend_q, pend_d;
`endif

    assign map_r = map_byte(cur_q);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cur_d   = cur_q;
        k_d     = k_q;
        s_d     = s_q;
        keys_d  = keys_q;
        pop     = 1'b0;
`ifdef SERKBD_ANSI_EN
        pend_d  = pend_q;
`endif
        unique case (state_q)
            StIdle: if (!fifo_empty) state_d = StPop;
            StPop: begin
                pop     = 1'b1;
                cur_d   = fifo_rdata;
                state_d = StMap;
            end
            StMap: begin
`ifdef SERKBD_ANSI_EN
                if (cur_q == 8'h1B) begin
                    cnt_d   = CNT_W'(ESC_TIMEOUT - 1);
                    state_d = StEsc1;
                end else
`endif
                if (map_r[7]) begin
                    k_d     = map_r[5:0];
                    s_d     = map_r[6];
                    state_d = StPress;
                end else begin
                    state_d = StIdle;
                end
            end
            StPress: begin
                keys_d[k_q] = 1'b1;
                if (s_q) keys_d[KEY_SHIFT] = 1'b1;
                cnt_d   = CNT_W'(HOLD_CYCLES - 1);
                state_d = StHold;
            end
            StHold: begin
                if (cnt_q == '0) state_d = StRelease;
                else             cnt_d   = cnt_q - 1'b1;
            end
            StRelease: begin
                keys_d  = '0;
                cnt_d   = CNT_W'(GAP_CYCLES - 1);
                state_d = StGap;
            end
            StGap: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
`ifdef SERKBD_ANSI_EN
                end else if (pend_q) begin
                    pend_d  = 1'b0;
                    state_d = StMap;
`endif
                end else begin
                    state_d = StIdle;
                end
            end
`ifdef SERKBD_ANSI_EN
            StEsc1: begin
                if (!fifo_empty) begin
                    pop = 1'b1;
                    if (fifo_rdata == 8'h5B) begin
                        cnt_d   = CNT_W'(ESC_TIMEOUT - 1);
                        state_d = StEsc2;
                    end else begin
                        cur_d   = fifo_rdata;
                        pend_d  = 1'b1;
                        k_d     = KEY_BREAK;
                        s_d     = 1'b0;
                        state_d = StPress;
                    end
                end else if (cnt_q == '0) begin
                    k_d     = KEY_BREAK;
                    s_d     = 1'b0;
                    state_d = StPress;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StEsc2: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    s_d     = 1'b0;
                    state_d = StPress;
                    case (fifo_rdata)
                        8'h41:   k_d = 6'd27;       // up
                        8'h42:   k_d = 6'd28;       // down
                        8'h43:   k_d = 6'd30;       // right
                        8'h44:   k_d = 6'd29;       // left
                        default: state_d = StIdle;  // unknown final byte dropped
                    endcase
                end else if (cnt_q == '0) begin
                    k_d     = KEY_BREAK;
                    s_d     = 1'b0;
                    state_d = StPress;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
`endif
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            cur_q   <= '0;
            k_q     <= '0;
            s_q     <= 1'b0;
            keys_q  <= '0;
`ifdef SERKBD_ANSI_EN
            pend_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cur_q   <= cur_d;
            k_q     <= k_d;
            s_q     <= s_d;
            keys_q  <= keys_d;
`ifdef SERKBD_ANSI_EN
            pend_q  <= pend_d;
`endif
        end
    end

    // ----------------------------------------------------------- read port
    logic [7:0] key_out_q;

    always_ff @(posedge clk) begin
        if (!reset_n)    key_out_q <= 8'hFF;
        else if (rd_key) key_out_q <= keys_q[key_addr] ? 8'hFE : 8'hFF;
    end

    assign key_out  = key_out_q;
    assign busy     = (state_q != StIdle) || !fifo_empty;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_serial_key_matrix.sv
module tb_serial_key_matrix;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rd_key;
    logic [5:0] key_addr;
    logic [7:0] key_out;
    logic       busy;
    logic       overflow;

    int         checks = 0;
    int         errors = 0;
    int         n_pressed;
    logic [7:0] v;

    serial_key_matrix #(
        .F_CLK      (25000000),
        .HOLD_CYCLES(8),
        .GAP_CYCLES (4),
        .FIFO_AW    (2),
        .ESC_TIMEOUT(16)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .rx_data (rx_data),
        .rx_valid(rx_valid),
        .rd_key  (rd_key),
        .key_addr(key_addr),
        .key_out (key_out),
        .busy    (busy),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic read_key(input logic [5:0] addr, output logic [7:0] val);
        key_addr = addr;
        rd_key   = 1'b1;
        tick();
        rd_key   = 1'b0;
        val      = key_out;
    endtask

    // Polls one key until it reads pressed; an expired bound is a failed check.
    task automatic wait_press(input string tag, input logic [5:0] addr, input int bound);
        logic       hit;
        logic [7:0] r;
        hit = 1'b0;
        for (int i = 0; i < bound && !hit; i++) begin
            read_key(addr, r);
            if (r == 8'hFE) hit = 1'b1;
        end
        check(tag, {7'd0, hit}, 8'd1);
    endtask

    task automatic wait_idle(input string tag, input int bound);
        for (int i = 0; i < bound && busy; i++) tick();
        check(tag, {7'd0, busy}, 8'd0);
    endtask

    initial begin
        reset_n  = 1'b0;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        rd_key   = 1'b0;
        key_addr = 6'd0;
        tick();
        tick();
        reset_n = 1'b1;

        // Reset state
        check("reset key_out", key_out, 8'hFF);
        check("reset busy", {7'd0, busy}, 8'd0);
        check("reset overflow", {7'd0, overflow}, 8'd0);

        // 1: 'A' -> key 1; press lands 4 clocks after the rx strobe edge
        send(8'h41);
        repeat (4) tick();
        read_key(6'd1, v);
        check("t1 key1 held", v, 8'hFE);
        read_key(6'd2, v);
        check("t1 key2 idle", v, 8'hFF);
        check("t1 busy", {7'd0, busy}, 8'd1);
        wait_idle("t1 idle", 40);
        read_key(6'd1, v);
        check("t1 key1 released", v, 8'hFF);

        // 2: shifted and unshifted punctuation
        send(8'h21);
        wait_press("t2 ! key33", 6'd33, 20);
        read_key(6'd53, v);
        check("t2 ! shift", v, 8'hFE);
        wait_idle("t2 idle a", 40);
        send(8'h3B);
        wait_press("t2 ; key42", 6'd42, 20);
        read_key(6'd53, v);
        check("t2 ; no shift", v, 8'hFF);
        wait_idle("t2 idle b", 40);

        // 3: burst of 5 while busy with an empty FIFO: 4 kept, 5th dropped
        send(8'h41);
        tick();
        tick();
        send(8'h42);
        send(8'h43);
        send(8'h44);
        send(8'h45);
        send(8'h46);
        check("t3 overflow set", {7'd0, overflow}, 8'd1);
        wait_press("t3 B", 6'd2, 60);
        read_key(6'd3, v);
        check("t3 C after B", v, 8'hFF);
        wait_press("t3 C", 6'd3, 40);
        wait_press("t3 D", 6'd4, 40);
        wait_press("t3 E", 6'd5, 40);
        read_key(6'd6, v);
        check("t3 F not pressed", v, 8'hFF);
        wait_idle("t3 idle (F dropped)", 20);
        check("t3 overflow sticky", {7'd0, overflow}, 8'd1);

        // 4: reset mid-HOLD with a byte queued
        send(8'h47);
        wait_press("t4 G", 6'd7, 20);
        send(8'h48);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        check("t4 key_out", key_out, 8'hFF);
        check("t4 busy", {7'd0, busy}, 8'd0);
        check("t4 overflow", {7'd0, overflow}, 8'd0);
        read_key(6'd7, v);
        check("t4 key7 cleared", v, 8'hFF);
        repeat (5) tick();
        check("t4 fifo flushed", {7'd0, busy}, 8'd0);

        // 5: unmapped byte
        send(8'h7E);
        repeat (4) tick();
        check("t5 busy", {7'd0, busy}, 8'd0);
        n_pressed = 0;
        for (int a = 0; a < 64; a++) begin
            read_key(6'(a), v);
            if (v == 8'hFE) n_pressed++;
        end
        check("t5 no key", 8'(n_pressed), 8'd0);

        // 6: escape handling
`ifdef SERKBD_ANSI_EN
        send(8'h1B);
        send(8'h5B);
        send(8'h41);
        wait_press("t6 up", 6'd27, 40);
        read_key(6'd49, v);
        check("t6 no break", v, 8'hFF);
        read_key(6'd1, v);
        check("t6 no A", v, 8'hFF);
        wait_idle("t6 idle a", 40);

        send(8'h1B);
        repeat (10) tick();
        read_key(6'd49, v);
        check("t6 lone esc waiting", v, 8'hFF);
        check("t6 lone esc busy", {7'd0, busy}, 8'd1);
        wait_press("t6 lone esc break", 6'd49, 30);
        wait_idle("t6 idle b", 40);

        send(8'h1B);
        send(8'h42);
        wait_press("t6 esc B break", 6'd49, 40);
        read_key(6'd2, v);
        check("t6 B after break", v, 8'hFF);
        wait_press("t6 B fresh", 6'd2, 40);
        wait_idle("t6 idle c", 40);
`else
        send(8'h1B);
        send(8'h5B);
        send(8'h41);
        wait_press("t6 break", 6'd49, 40);
        read_key(6'd1, v);
        check("t6 A after break", v, 8'hFF);
        wait_press("t6 A", 6'd1, 40);
        wait_idle("t6 idle", 40);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
